vc_assoc_cache: RTL and testbench

- Parametrised, fully-associative victim cache between the L2 cache and physical memory.
- Holds lines the L2 evicts, together with their dirty state.
- Serves L2 read misses from its own entries and swaps a hit line back out, so the victim cache stays exclusive of the L2.
- On a miss it forwards the read to pmem. When full, it writes back a dirty LRU victim before installing a new line.

---
 rtl/vc_assoc_cache.sv | 199 +++++++++++++++++++
 tb/tb_vc_assoc_cache.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_assoc_cache.sv
// Fully-associative victim cache between L2 and physical memory.
// Exclusive of L2: read hits are handed back and invalidated here.
module vc_assoc_cache #(
    parameter int ENTRIES     = 4,
    parameter int LINE_BITS   = 256,
    parameter int ADDR_BITS   = 16,
    parameter int OFFSET_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l2_read,
    input  logic                 l2_write,
    input  logic [ADDR_BITS-1:0] l2_address,
    input  logic [LINE_BITS-1:0] l2_wdata,
    input  logic                 l2_wdirty,
    output logic [LINE_BITS-1:0] l2_rdata,
    output logic                 l2_rdirty,
    output logic                 l2_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [ADDR_BITS-1:0] pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        RD_HIT,
        RD_MISS,
        WB,
        INSTALL
    } state_t;

    state_t               state;
    logic [TW-1:0]        tags  [ENTRIES];
    logic [LINE_BITS-1:0] lines [ENTRIES];
    logic [IW-1:0]        age   [ENTRIES];
    logic [ENTRIES-1:0]   valid;
    logic [ENTRIES-1:0]   dirty;

    logic [TW-1:0]        req_tag;
    logic [IW-1:0]        req_idx;
    logic [LINE_BITS-1:0] req_data;
    logic                 req_dirty;
    logic [TW-1:0]        wb_tag;
    logic [LINE_BITS-1:0] wb_data;

    logic [TW-1:0] l2_tag;
    logic          hit;
    logic          full;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] lru_idx;
    logic [IW-1:0] lru_age;
    logic          lru_found;

    assign l2_tag = l2_address[ADDR_BITS-1:OFFSET_BITS];

    always_comb begin
        hit       = 1'b0;
        full      = 1'b1;
        hit_idx   = '0;
        free_idx  = '0;
        lru_idx   = '0;
        lru_age   = '0;
        lru_found = 1'b0;
        // Descending scan so the lowest free index wins
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                full     = 1'b0;
                free_idx = IW'(i);
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tags[i] == l2_tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (valid[i] && (!lru_found || age[i] > lru_age)) begin
                lru_found = 1'b1;
                lru_idx   = IW'(i);
                lru_age   = age[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            req_tag   <= '0;
            req_idx   <= '0;
            req_data  <= '0;
            req_dirty <= 1'b0;
            wb_tag    <= '0;
            wb_data   <= '0;
            for (int j = 0; j < ENTRIES; j++) begin
                age[j] <= IW'(j);
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (l2_write) begin
                        req_tag  <= l2_tag;
                        req_data <= l2_wdata;
                        state    <= INSTALL;
                        if (hit) begin
                            req_idx   <= hit_idx;
                            req_dirty <= dirty[hit_idx] | l2_wdirty;
                        end else if (!full) begin
                            req_idx   <= free_idx;
                            req_dirty <= l2_wdirty;
                        end else begin
                            req_idx   <= lru_idx;
                            req_dirty <= l2_wdirty;
                            if (dirty[lru_idx]) begin
                                wb_tag  <= tags[lru_idx];
                                wb_data <= lines[lru_idx];
                                state   <= WB;
                            end
                        end
                    end else if (l2_read) begin
                        req_tag <= l2_tag;
                        req_idx <= hit_idx;
                        state   <= hit ? RD_HIT : RD_MISS;
                    end
                end
                RD_HIT: begin
                    valid[req_idx] <= 1'b0;
                    dirty[req_idx] <= 1'b0;
                    state          <= IDLE;
                end
                RD_MISS: begin
                    if (pmem_resp) state <= IDLE;
                end
                WB: begin
                    if (pmem_resp) state <= INSTALL;
                end
                INSTALL: begin
                    valid[req_idx] <= 1'b1;
                    dirty[req_idx] <= req_dirty;
                    for (int j = 0; j < ENTRIES; j++) begin
                        if (valid[j] && IW'(j) != req_idx
                            && age[j] < age[req_idx]) begin
                            age[j] <= age[j] + 1'b1;
                        end
                    end
                    age[req_idx] <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line payload needs no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if (state == INSTALL) begin
            tags[req_idx]  <= req_tag;
            lines[req_idx] <= req_data;
        end
    end

    always_comb begin
        l2_rdata     = '0;
        l2_rdirty    = 1'b0;
        l2_resp      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state)
            RD_HIT: begin
                l2_rdata  = lines[req_idx];
                l2_rdirty = dirty[req_idx];
                l2_resp   = 1'b1;
            end
            RD_MISS: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, {OFFSET_BITS{1'b0}}};
                l2_rdata     = pmem_rdata;
                l2_resp      = pmem_resp;
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {wb_tag, {OFFSET_BITS{1'b0}}};
                pmem_wdata   = wb_data;
            end
            INSTALL: l2_resp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vc_assoc_cache.sv
// Scenario bench for vc_assoc_cache: expected transaction outcomes
// are queued on issue and compared when the L2 response arrives.
module tb_vc_assoc_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [255:0] l2_wdata;
    logic         l2_wdirty;
    logic [255:0] l2_rdata;
    logic         l2_rdirty;
    logic         l2_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [255:0] rdata;
        logic         rdirty;
        logic [7:0]   lat;
        logic [1:0]   kind;
        logic [15:0]  paddr;
        logic [255:0] pwdata;
        logic         tout;
    } obs_t;

    obs_t exp_q[$];

    vc_assoc_cache dut (
        .clk          (clk),
        .rst          (rst),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_wdirty    (l2_wdirty),
        .l2_rdata     (l2_rdata),
        .l2_rdirty    (l2_rdirty),
        .l2_resp      (l2_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [7:0] s);
        return {32{s}} ^ {8{32'h0123_4567}};
    endfunction

    // kind: 0 none, 1 pmem read, 2 pmem write
    function automatic obs_t mk(input logic [255:0] rd, input logic rdy,
                                input int lat, input int kind,
                                input logic [15:0] pa,
                                input logic [255:0] pw);
        obs_t o;
        o.rdata  = rd;
        o.rdirty = rdy;
        o.lat    = 8'(lat);
        o.kind   = 2'(kind);
        o.paddr  = pa;
        o.pwdata = pw;
        o.tout   = 1'b0;
        return o;
    endfunction

    function automatic logic [532:0] outs();
        return {l2_rdata, l2_rdirty, l2_resp, pmem_read, pmem_write,
                pmem_address, pmem_wdata};
    endfunction

    task automatic idle_inputs();
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        l2_wdirty  = 1'b0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drives one L2 request from a negedge, plays memory with the given
    // delay, and records what the DUT did until l2_resp.
    task automatic l2_txn(input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [255:0] wd,
                          input logic wdirty, input logic [255:0] md,
                          input int delay, output obs_t o);
        int pcnt;
        logic done;
        o      = '0;
        pcnt   = 0;
        done   = 1'b0;
        l2_read    = rd;
        l2_write   = wr;
        l2_address = addr;
        l2_wdata   = wd;
        l2_wdirty  = wdirty;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            o.lat = o.lat + 8'd1;
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) begin
                if (o.kind == 2'd0) begin
                    o.kind   = pmem_read ? 2'd1 : 2'd2;
                    o.paddr  = pmem_address;
                    o.pwdata = pmem_wdata;
                end
                pcnt++;
                if (pcnt >= delay) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = md;
                end
            end
            #1;
            if (l2_resp) begin
                o.rdata  = l2_rdata;
                o.rdirty = l2_rdirty;
                done     = 1'b1;
            end
        end
        o.tout   = !done;
        l2_read  = 1'b0;
        l2_write = 1'b0;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input string name, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [255:0] wd,
                       input logic wdirty, input logic [255:0] md,
                       input int delay, input obs_t e);
        obs_t got;
        obs_t want;
        exp_q.push_back(e);
        l2_txn(rd, wr, addr, wd, wdirty, md, delay, got);
        want = exp_q.pop_front();
        total++;
        if (got !== want)
            $display("FAIL %s got=%h want=%h", name, got, want);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        l2_read = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (outs() !== '0)
            $display("FAIL reset_outs got=%h want=0", outs());
        else
            passed++;
        do_reset();
    endtask

    task automatic test_read_miss();
        do_reset();
        run("read_miss", 1, 0, 16'h1234, '0, 0, pat(8'h11), 3,
            mk(pat(8'h11), 0, 3, 1, 16'h1220, '0));
    endtask

    task automatic test_write_hit();
        do_reset();
        run("wr_1220", 0, 1, 16'h1220, pat(8'hA0), 1, '0, 1,
            mk('0, 0, 1, 0, 16'h0, '0));
        run("rd_hit_1231", 1, 0, 16'h1231, '0, 0, '0, 1,
            mk(pat(8'hA0), 1, 1, 0, 16'h0, '0));
        run("rd_again_miss", 1, 0, 16'h1220, '0, 0, pat(8'h22), 2,
            mk(pat(8'h22), 0, 2, 1, 16'h1220, '0));
    endtask

    task automatic test_clean_evict();
        do_reset();
        for (int i = 0; i < 4; i++)
            run("fill_clean", 0, 1, 16'(i * 32), pat(8'(i)), 0, '0, 1,
                mk('0, 0, 1, 0, 16'h0, '0));
        run("evict_clean", 0, 1, 16'h0080, pat(8'h80), 0, '0, 1,
            mk('0, 0, 1, 0, 16'h0, '0));
        run("rd_evicted", 1, 0, 16'h0000, '0, 0, pat(8'h33), 1,
            mk(pat(8'h33), 0, 1, 1, 16'h0000, '0));
        run("rd_kept", 1, 0, 16'h0020, '0, 0, '0, 1,
            mk(pat(8'h01), 0, 1, 0, 16'h0, '0));
    endtask

    task automatic test_dirty_wb();
        do_reset();
        for (int i = 0; i < 4; i++)
            run("fill_mixed", 0, 1, 16'(i * 32), pat(8'(8'h40 + i)),
                i == 0, '0, 1, mk('0, 0, 1, 0, 16'h0, '0));
        run("evict_dirty", 0, 1, 16'h0080, pat(8'h88), 0, '0, 3,
            mk('0, 0, 4, 2, 16'h0000, pat(8'h40)));
        run("rd_new", 1, 0, 16'h009F, '0, 0, '0, 1,
            mk(pat(8'h88), 0, 1, 0, 16'h0, '0));
        run("rd_wb_line", 1, 0, 16'h0000, '0, 0, pat(8'h44), 2,
            mk(pat(8'h44), 0, 2, 1, 16'h0000, '0));
    endtask

    task automatic test_rewrite();
        do_reset();
        run("wr_old", 0, 1, 16'h0040, pat(8'h50), 1, '0, 1,
            mk('0, 0, 1, 0, 16'h0, '0));
        run("rewrite", 0, 1, 16'h0045, pat(8'h51), 0, '0, 1,
            mk('0, 0, 1, 0, 16'h0, '0));
        run("fill_0000", 0, 1, 16'h0000, pat(8'h52), 0, '0, 1,
            mk('0, 0, 1, 0, 16'h0, '0));
        run("fill_0020", 0, 1, 16'h0020, pat(8'h53), 0, '0, 1,
            mk('0, 0, 1, 0, 16'h0, '0));
        run("fill_0060", 0, 1, 16'h0060, pat(8'h54), 0, '0, 1,
            mk('0, 0, 1, 0, 16'h0, '0));
        run("rd_rewritten", 1, 0, 16'h0040, '0, 0, '0, 1,
            mk(pat(8'h51), 1, 1, 0, 16'h0, '0));
    endtask

    task automatic test_back_to_back();
        int lat;
        do_reset();
        l2_write   = 1'b1;
        l2_read    = 1'b1;
        l2_address = 16'h0100;
        l2_wdata   = pat(8'h66);
        l2_wdirty  = 1'b1;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
            if (l2_resp) break;
        end
        total++;
        if (!l2_resp || lat != 1 || l2_rdata !== '0)
            $display("FAIL b2b_write resp=%b lat=%0d want resp=1 lat=1",
                     l2_resp, lat);
        else
            passed++;
        l2_write = 1'b0;
        run("b2b_read", 1, 0, 16'h0100, '0, 0, '0, 1,
            mk(pat(8'h66), 1, 2, 0, 16'h0, '0));
    endtask

    task automatic test_reset_mid_wb();
        logic seen;
        do_reset();
        for (int i = 0; i < 4; i++)
            run("fill_dirty", 0, 1, 16'(i * 32), pat(8'(8'h70 + i)), 1,
                '0, 1, mk('0, 0, 1, 0, 16'h0, '0));
        l2_write   = 1'b1;
        l2_address = 16'h0080;
        l2_wdata   = pat(8'h77);
        l2_wdirty  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = pmem_write;
        end
        total++;
        if (!seen)
            $display("FAIL wb_start pmem_write=0 want=1");
        else
            passed++;
        rst = 1'b1;
        #1;
        total++;
        if (outs() !== '0)
            $display("FAIL rst_in_wb got=%h want=0", outs());
        else
            passed++;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("rd_after_rst", 1, 0, 16'h0000, '0, 0, pat(8'h99), 1,
            mk(pat(8'h99), 0, 1, 1, 16'h0000, '0));
        run("rd_after_rst2", 1, 0, 16'h0060, '0, 0, pat(8'h9A), 1,
            mk(pat(8'h9A), 0, 1, 1, 16'h0060, '0));
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_clean_evict();
        test_dirty_wb();
        test_rewrite();
        test_back_to_back();
        test_reset_mid_wb();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
